// File: rtl/qdiv_pkg.sv
// Shared types and sizing helpers for the sequential sign-magnitude divider.
package qdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } qdiv_state_t;

  localparam int QDIV_N_DEF = 32;
  localparam int QDIV_Q_DEF = 15;

  // One quotient bit per integer-magnitude bit plus one per fractional bit.
  function automatic int qdiv_iter(input int n, input int q);
    return n - 1 + q;
  endfunction

  localparam int QDIV_ITER_DEF = qdiv_iter(QDIV_N_DEF, QDIV_Q_DEF);
  localparam int QDIV_CNT_W    = $clog2(QDIV_ITER_DEF + 1);

endpackage

// File: rtl/qdiv_step.sv
// One radix-2 restoring division step: shift in the next numerator bit, subtract if it fits.
module qdiv_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem,
  input  logic         bit_in,
  input  logic [N-2:0] den,
  output logic [N-1:0] rem_next,
  output logic         qbit
);

  logic [N:0]   shifted_s;
  logic [N-1:0] diff_s;

  // Partial remainder update and quotient bit decision.
  always_comb begin
    shifted_s = {rem, bit_in};
    diff_s    = shifted_s[N-1:0] - {1'b0, den};
    if (shifted_s >= {2'b00, den}) begin
      qbit     = 1'b1;
      rem_next = diff_s;
    end else begin
      qbit     = 1'b0;
      rem_next = shifted_s[N-1:0];
    end
  end

endmodule

// File: rtl/qdiv_seq.sv
// Sequential sign-magnitude fixed-point divider, one quotient bit per clock.
// Optional QDIV_ROUND_EN: one extra guard quotient bit, magnitude rounded half-up.
module qdiv_seq
  import qdiv_pkg::*;
#(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_result,
  output logic         o_ovr,
  output logic         o_dbz
);

  localparam int ITER = qdiv_iter(N, Q);
`ifdef QDIV_ROUND_EN
  localparam int NIT = ITER + 1;
`else
  localparam int NIT = ITER;
`endif
  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(NIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  qdiv_state_t    state_r;
  logic           sign_r;
  logic           dbz_r;
  logic [NIT-1:0] num_r;
  logic [NIT-1:0] quot_r;
  logic [N-2:0]   den_r;
  logic [N-1:0]   rem_r;
  logic [CW-1:0]  cnt_r;

  logic [N-1:0]   rem_nx_s;
  logic           qbit_s;
  logic [N-2:0]   mag_s;
  logic           ovr_s;
`ifdef QDIV_ROUND_EN
  logic [N-1:0]   rnd_s;
`endif

  qdiv_step #(.N(N)) u_step (
    .rem      (rem_r),
    .bit_in   (num_r[NIT-1]),
    .den      (den_r),
    .rem_next (rem_nx_s),
    .qbit     (qbit_s)
  );

  // Final magnitude: saturate when the quotient needs more than N-1 integer+fraction bits.
  always_comb begin
    mag_s = {(N-1){1'b0}};
    ovr_s = 1'b0;
`ifdef QDIV_ROUND_EN
    rnd_s = {1'b0, quot_r[N-1:1]} + {{(N-1){1'b0}}, quot_r[0]};
    if ((|quot_r[NIT-1:N]) || rnd_s[N-1]) begin
      ovr_s = 1'b1;
      mag_s = {(N-1){1'b1}};
    end else begin
      mag_s = rnd_s[N-2:0];
    end
`else
    if (|quot_r[NIT-1:N-1]) begin
      ovr_s = 1'b1;
      mag_s = {(N-1){1'b1}};
    end else begin
      mag_s = quot_r[N-2:0];
    end
`endif
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      sign_r   <= 1'b0;
      dbz_r    <= 1'b0;
      num_r    <= {NIT{1'b0}};
      quot_r   <= {NIT{1'b0}};
      den_r    <= {(N-1){1'b0}};
      rem_r    <= {N{1'b0}};
      cnt_r    <= {CW{1'b0}};
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= {N{1'b0}};
      o_ovr    <= 1'b0;
      o_dbz    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_start) begin
            sign_r <= i_dividend[N-1] ^ i_divisor[N-1];
            num_r  <= {i_dividend[N-2:0], {(NIT-N+1){1'b0}}};
            den_r  <= i_divisor[N-2:0];
            rem_r  <= {N{1'b0}};
            quot_r <= {NIT{1'b0}};
            cnt_r  <= CNT_LOAD;
            o_busy <= 1'b1;
            if (i_divisor[N-2:0] == {(N-1){1'b0}}) begin
              dbz_r   <= 1'b1;
              state_r <= DONE;
            end else begin
              dbz_r   <= 1'b0;
              state_r <= DIV;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        DIV: begin
          rem_r  <= rem_nx_s;
          quot_r <= {quot_r[NIT-2:0], qbit_s};
          num_r  <= {num_r[NIT-2:0], 1'b0};
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        DONE: begin
          o_done   <= 1'b1;
          o_busy   <= 1'b0;
          o_dbz    <= dbz_r;
          o_ovr    <= dbz_r | ovr_s;
          o_result <= {sign_r, (dbz_r ? {(N-1){1'b1}} : mag_s)};
          state_r  <= IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qdiv_seq.sv
// Self-checking bench for qdiv_seq (Q=15, N=32): table vectors, random model vectors, abort sequence.
module tb_qdiv_seq;

  localparam int N = 32;
  localparam int Q = 15;
`ifdef QDIV_ROUND_EN
  localparam int          LAT   = 48;
  localparam logic [31:0] THIRD = 32'h0000_2AAB;
`else
  localparam int          LAT   = 47;
  localparam logic [31:0] THIRD = 32'h0000_2AAA;
`endif

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] res;
    logic        ovr;
    logic        dbz;
    int          lat;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;
  logic        o_ovr;
  logic        o_dbz;

  int   n_cmp;
  int   n_mis;
  vec_t sb_q[$];
  vec_t vecs[7];

  qdiv_seq #(.Q(Q), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result),
    .o_ovr      (o_ovr),
    .o_dbz      (o_dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: integer division of the scaled magnitudes.
  function automatic vec_t mk(input logic [31:0] dvd, input logic [31:0] dvs);
    vec_t v;
    logic [63:0] num;
    logic [63:0] den;
    logic [63:0] qv;
    v.dvd = dvd;
    v.dvs = dvs;
    v.ovr = 1'b0;
    v.dbz = 1'b0;
    v.lat = LAT;
    den = {33'd0, dvs[30:0]};
    num = {33'd0, dvd[30:0]} << Q;
    if (den == 64'd0) begin
      v.dbz = 1'b1;
      v.ovr = 1'b1;
      v.lat = 1;
      qv    = 64'h7FFF_FFFF;
    end else begin
`ifdef QDIV_ROUND_EN
      qv = (((num << 1) / den) + 64'd1) >> 1;
`else
      qv = num / den;
`endif
      if (qv > 64'h7FFF_FFFF) begin
        v.ovr = 1'b1;
        qv    = 64'h7FFF_FFFF;
      end
    end
    v.res = {dvd[31] ^ dvs[31], qv[30:0]};
    return v;
  endfunction

  task automatic run_job(input vec_t v, input bit pulse);
    vec_t e;
    int   got;
    @(negedge clk);
    i_dividend = v.dvd;
    i_divisor  = v.dvs;
    i_start    = 1'b1;
    sb_q.push_back(v);
    @(negedge clk);
    i_start    = 1'b0;
    i_dividend = $urandom;
    i_divisor  = $urandom;
    chk("busy_after_start", {63'd0, o_busy}, 64'd1);
    got = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_done) begin
        got = k;
        break;
      end
      if (pulse && (k == 5 || k == 20 || k == LAT - 1)) begin
        i_start    = 1'b1;
        i_dividend = $urandom;
        i_divisor  = $urandom;
      end
    end
    if (got == 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL done_timeout: no o_done within 200 cycles for %h / %h", v.dvd, v.dvs);
      sb_q.delete();
    end else begin
      e = sb_q.pop_front();
      chk("result",  {32'd0, o_result}, {32'd0, e.res});
      chk("ovr",     {63'd0, o_ovr},    {63'd0, e.ovr});
      chk("dbz",     {63'd0, o_dbz},    {63'd0, e.dbz});
      chk("latency", 64'(got),          64'(e.lat));
    end
    @(negedge clk);
    chk("done_one_cycle_busy_clear", {62'd0, o_done, o_busy}, 64'd0);
  endtask

  initial begin
    int   ndone;
    vec_t v;
    n_cmp      = 0;
    n_mis      = 0;
    rst        = 1'b0;
    i_start    = 1'b0;
    i_dividend = 32'd0;
    i_divisor  = 32'd0;

    vecs[0] = '{32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 1'b0, LAT};
    vecs[1] = '{32'h8000_8000, 32'h0002_0000, 32'h8000_2000, 1'b0, 1'b0, LAT};
    vecs[2] = '{32'h0000_8000, 32'h0001_8000, THIRD,         1'b0, 1'b0, LAT};
    vecs[3] = '{32'h0000_8000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1};
    vecs[4] = '{32'h4000_0000, 32'h0000_4000, 32'h7FFF_FFFF, 1'b1, 1'b0, LAT};
    vecs[5] = '{32'h8000_0000, 32'h0000_8000, 32'h8000_0000, 1'b0, 1'b0, LAT};
    vecs[6] = '{32'h8001_4000, 32'h8000_4000, 32'h0002_8000, 1'b0, 1'b0, LAT};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {29'd0, o_busy, o_done, o_ovr, o_dbz, o_result}, 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i], (i == 0));
    end

    for (int i = 0; i < 6; i++) begin
      logic [31:0] dvd;
      logic [31:0] dvs;
      dvd = $urandom;
      dvs = $urandom;
      if (i < 3) begin
        dvd[30:0] = 31'($urandom_range(0, 32'h0010_0000));
        dvs[30:0] = 31'($urandom_range(1, 32'h0040_0000));
      end
      run_job(mk(dvd, dvs), (i == 4));
    end

    // Abort a job mid-division; outputs drop at once and no completion follows.
    @(negedge clk);
    i_dividend = 32'h0001_8000;
    i_divisor  = 32'h0001_0000;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_outputs", {29'd0, o_busy, o_done, o_ovr, o_dbz, o_result}, 64'd0);
    @(negedge clk);
    rst   = 1'b1;
    ndone = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    v = mk(32'h0001_8000, 32'h0001_0000);
    chk("model_3_over_2", {32'd0, v.res}, 64'h0000_0000_0000_C000);
    run_job(v, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_mis);
    $finish;
  end

endmodule
